// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and access-size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data storage with per-byte write enables; read is combinational and registered by the parent.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: req/ready handshake with WAIT wait states, word/byte lanes, and error reporting.
// Storage is touched only on the edge that enters RESP, so a reset during WAIT drops the access.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        enter_resp;
    logic        acc_we, acc_size, acc_err;
    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  lane;
    logic        arr_we;
    logic [3:0]  arr_be;
    logic [31:0] arr_wdata, arr_rdata;

    // With WAIT=0 the access happens on the capture edge, so use the live inputs in IDLE.
    always_comb begin
        acc_we    = (state_q == ST_IDLE) ? we    : we_q;
        acc_size  = (state_q == ST_IDLE) ? size  : size_q;
        acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
        acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
        lane      = acc_addr[1:0];
        acc_err   = ((acc_size == SIZE_WORD) && (lane != 2'b00)) ||
                    (acc_addr[31:2] >= 30'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arr_we    = enter_resp && acc_we && !acc_err;
        arr_be    = (acc_size == SIZE_BYTE) ? (4'b0001 << lane) : 4'b1111;
        arr_wdata = (acc_size == SIZE_BYTE) ? {4{acc_wdata[7:0]}} : acc_wdata;

        ready_d = enter_resp;
        err_d   = enter_resp && acc_err;
        busy_d  = (state_d != ST_IDLE);
        rdata_d = 32'd0;
        if (enter_resp && !acc_err && !acc_we) begin
            rdata_d = (acc_size == SIZE_BYTE) ? {24'd0, arr_rdata[8*lane +: 8]} : arr_rdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .idx   (acc_addr[AW+1:2]),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SIZE_WORD;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT = 1, 0 and 3 share clock and reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req   [3];
    logic        we    [3];
    logic        size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH(64), .WAIT(1)) u0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));
    dmem_responder #(.DEPTH(64), .WAIT(0)) u1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));
    dmem_responder #(.DEPTH(64), .WAIT(3)) u2 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .size(size[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for idle, presents one request, and reports edges from capture to ready.
    // With scramble set, we/addr/wdata are corrupted right after the capture edge.
    task automatic access(input int i, input logic w, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          output int lat, output logic [31:0] rd, output logic e);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy[i] && guard < 20);
        req[i] = 1'b1; we[i] = w; size[i] = s; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        if (scramble) begin
            we[i] = ~w; addr[i] = ~a; wdata[i] = ~d;
        end
        lat = 0;
        while (!ready[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req[i] = 1'b0;
        rd = rdata[i];
        e  = err[i];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ready[i], err[i], busy[i], rdata[i]} !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: ready=%b err=%b busy=%b rdata=%h, required all 0",
                         i, ready[i], err[i], busy[i], rdata[i]);
            end
        end
    endtask

    task automatic test_word_store_load();
        int lat; logic [31:0] rd; logic e;
        access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, e);
        n_checks++;
        if (lat !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL word_store: lat=%0d err=%b, required lat=1 err=0", lat, e);
        end
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_load: lat=%0d err=%b rdata=%h, required 1/0/deadbeef", lat, e, rd);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic e;
        access(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 1'b0, lat, rd, e);
        access(0, 1'b1, 1'b1, 32'h11, 32'hFFFFFFAA, 1'b0, lat, rd, e);
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_store_err: err=%b, required 0", e);
        end
        access(0, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (rd !== 32'h000000AA || e !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_load_lane1: rdata=%h err=%b, required 000000aa/0", rd, e);
        end
        access(0, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (rd !== 32'h00000011) begin
            n_fail++;
            $display("FAIL byte_load_lane3: rdata=%h, required 00000011", rd);
        end
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (rd !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL byte_merge_word: rdata=%h, required 1122aa44", rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e;
        access(0, 1'b1, 1'b0, 32'h0, 32'h55AA55AA, 1'b0, lat, rd, e);
        access(0, 1'b0, 1'b0, 32'h12, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d, required 1/0/1", e, rd, lat);
        end
        access(0, 1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 1'b0, lat, rd, e);
        n_checks++;
        if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL range_store: err=%b rdata=%h lat=%0d, required 1/0/1", e, rd, lat);
        end
        access(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (e !== 1'b0 || rd !== 32'h55AA55AA) begin
            n_fail++;
            $display("FAIL word0_intact: err=%b rdata=%h, required 0/55aa55aa", e, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e;
        int guard = 0;
        access(1, 1'b1, 1'b0, 32'h4, 32'h0000BEEF, 1'b0, lat, rd, e);
        n_checks++;
        if (lat !== 0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_latency: lat=%0d err=%b, required 0/0", lat, e);
        end
        do begin
            @(negedge clk);
            guard++;
        end while (busy[1] && guard < 20);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 1'b0; addr[1] = 32'h4;
        for (int k = 0; k < 8; k++) begin
            logic exp;
            @(posedge clk); #1;
            exp = (k % 2 == 0);
            n_checks++;
            if (ready[1] !== exp || busy[1] !== exp || (exp && rdata[1] !== 32'h0000BEEF)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: ready=%b busy=%b rdata=%h, required ready=busy=%b rdata=0000beef",
                         k, ready[1], busy[1], rdata[1], exp);
            end
        end
        req[1] = 1'b0;
    endtask

    task automatic test_capture_hold();
        int lat; logic [31:0] rd; logic e;
        access(2, 1'b1, 1'b0, 32'h20, 32'h12345678, 1'b1, lat, rd, e);
        n_checks++;
        if (lat !== 3 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wait3_latency: lat=%0d err=%b, required 3/0", lat, e);
        end
        access(2, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL captured_store: rdata=%h err=%b, required 12345678/0", rd, e);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd; logic e;
        int guard = 0;
        access(2, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, lat, rd, e);
        do begin
            @(negedge clk);
            guard++;
        end while (busy[2] && guard < 20);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 1'b0; addr[2] = 32'h30; wdata[2] = 32'h0BADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy[2] !== 1'b1 || ready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_wait: busy=%b ready=%b, required 1/0", busy[2], ready[2]);
        end
        reset = 1'b0;
        #2;
        n_checks++;
        if ({ready[2], err[2], busy[2], rdata[2]} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset_clear: ready=%b err=%b busy=%b rdata=%h, required all 0",
                     ready[2], err[2], busy[2], rdata[2]);
        end
        req[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(2, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, lat, rd, e);
        n_checks++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0 || lat !== 3) begin
            n_fail++;
            $display("FAIL dropped_store: rdata=%h err=%b lat=%0d, required cafef00d/0/3", rd, e, lat);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; size[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        #23;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_word_store_load();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_capture_hold();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
